// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x-oversampling UART receiver with majority vote and output FIFO
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN (default build is 8N1).
module uart_rx_os16 #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_serial,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int              DIV      = CLK_FREQ / (BAUD_RATE * 16);
  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0]     DIV_LAST = 16'(DIV - 1);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        r_state, w_state_next;
  logic          r_sync1, r_sync2, r_rx_d;
  logic [15:0]   r_div;
  logic [3:0]    r_scnt, w_scnt_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_s7, r_s8;
  logic          r_frame_err, r_parity_err, r_overrun;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_tick, w_fall, w_maj, w_stop_eval, w_par_ok;
  logic w_full, w_pop, w_push_req, w_push;

  assign w_tick = (r_div == DIV_LAST);
  assign w_fall = r_rx_d & ~r_sync2;
  assign w_maj  = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);

`ifdef UART_RX_PARITY_EN
  logic r_par_bit, w_par_next;
  assign w_par_ok   = ~(r_par_bit ^ (^r_shift));
  assign parity_err = r_parity_err;
`else
  assign w_par_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_scnt_next  = r_scnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_stop_eval  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_next   = r_par_bit;
`endif
    case (r_state)
      S_IDLE: begin
        w_scnt_next = 4'd0;
        if (w_fall) w_state_next = S_START;
      end
      S_START: begin
        if (w_tick) begin
          w_scnt_next = r_scnt + 4'd1;
          if (r_scnt == 4'd9 && w_maj) begin
            w_state_next = S_IDLE;
            w_scnt_next  = 4'd0;
          end else if (r_scnt == 4'd15) begin
            w_state_next = S_DATA;
            w_scnt_next  = 4'd0;
            w_bit_next   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_scnt_next = r_scnt + 4'd1;
          if (r_scnt == 4'd9) w_shift_next = {w_maj, r_shift[7:1]};
          if (r_scnt == 4'd15) begin
            w_scnt_next = 4'd0;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              w_state_next = S_PARITY;
`else
              w_state_next = S_STOP;
`endif
            end else begin
              w_bit_next = r_bit + 3'd1;
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_scnt_next = r_scnt + 4'd1;
          if (r_scnt == 4'd9) w_par_next = w_maj;
          if (r_scnt == 4'd15) begin
            w_state_next = S_STOP;
            w_scnt_next  = 4'd0;
          end
        end
      end
`endif
      S_STOP: begin
        // Leave mid-stop-bit so the next start edge is never missed.
        if (w_tick) begin
          w_scnt_next = r_scnt + 4'd1;
          if (r_scnt == 4'd9) begin
            w_stop_eval  = 1'b1;
            w_state_next = S_IDLE;
            w_scnt_next  = 4'd0;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_scnt_next  = 4'd0;
      end
    endcase
  end

  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = (r_count != '0) & rx_ready;
  assign w_push_req = w_stop_eval & w_maj & w_par_ok;
  assign w_push     = w_push_req & (~w_full | w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_rx_d       <= 1'b1;
      r_div        <= 16'd0;
      r_scnt       <= 4'd0;
      r_bit        <= 3'd0;
      r_shift      <= 8'd0;
      r_s7         <= 1'b1;
      r_s8         <= 1'b1;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
`endif
    end else begin
      r_sync1      <= rx_serial;
      r_sync2      <= r_sync1;
      r_rx_d       <= r_sync2;
      r_div        <= w_tick ? 16'd0 : r_div + 16'd1;
      r_scnt       <= w_scnt_next;
      r_bit        <= w_bit_next;
      r_shift      <= w_shift_next;
      if (w_tick && r_scnt == 4'd7) r_s7 <= r_sync2;
      if (w_tick && r_scnt == 4'd8) r_s8 <= r_sync2;
      r_frame_err  <= w_stop_eval & ~w_maj;
      r_parity_err <= w_stop_eval & ~w_par_ok;
      r_overrun    <= w_push_req & w_full & ~w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= w_par_next;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  assign rx_valid   = (r_count != '0);
  assign rx_data    = rx_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign rx_busy    = (r_state != S_IDLE);
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign fifo_count = r_count;

endmodule
